// File: rtl/keys_in_pkg.sv
// rtl/keys_in_pkg.sv - shared types, constants and helpers for the keys_in block
package keys_in_pkg;

    // Widest key index any legal WIDTH (up to 16 keys) can need.
    localparam int KEY_MAX_W = 4;

    localparam logic EVT_RELEASE = 1'b0;
    localparam logic EVT_PRESS   = 1'b1;

    // One queued key event. The key index is sized for the widest legal
    // configuration; the top narrows it to its own index width on output.
    typedef struct packed {
        logic [KEY_MAX_W-1:0] key;
        logic                 press;
    } evt_t;

    // Width of a key index for a given number of keys, never less than 1.
    function automatic int key_idx_w(input int width);
        if (width <= 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/keys_in_chan.sv
// rtl/keys_in_chan.sv - one key channel: synchroniser, debounce, edge pulse (auto-repeat under KEYS_IN_AUTOREPEAT_EN)
module keys_in_chan
    import keys_in_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 50000
`ifdef KEYS_IN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = 25000000
`endif
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic level,
    output logic edge_pulse,
    output logic edge_dir
);

    // Pin level that means "not pressed"; XOR with it normalises polarity.
    localparam logic IDLE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          sample;
    logic [DW-1:0] db_cnt;
    logic          toggle;

    assign sample = sync2 ^ IDLE_PIN;
    assign toggle = (sample != level) && (db_cnt == DB_LAST);

    // Two-flop synchroniser; resets to the idle pin level so no false press.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= IDLE_PIN;
            sync2 <= IDLE_PIN;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: a differing sample must persist DEBOUNCE_CYCLES edges to flip level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (sample == level) begin
            db_cnt <= '0;
        end else if (toggle) begin
            db_cnt <= '0;
            level  <= ~level;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

`ifdef KEYS_IN_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_fire;

    // A real edge always wins over a repeat falling on the same cycle.
    assign rep_fire = level && !toggle && (rep_cnt == REP_LAST);

    // Repeat counter runs only while held and restarts on every edge or repeat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rep_cnt <= '0;
        end else if (toggle || !level || rep_fire) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    // Edge pulse coincides with the new level; repeats report as presses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            edge_pulse <= 1'b0;
            edge_dir   <= EVT_RELEASE;
        end else begin
            edge_pulse <= toggle || rep_fire;
            edge_dir   <= toggle ? ~level : EVT_PRESS;
        end
    end
`else
    // Edge pulse coincides with the new level; dir is the level being entered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            edge_pulse <= 1'b0;
            edge_dir   <= EVT_RELEASE;
        end else begin
            edge_pulse <= toggle;
            edge_dir   <= ~level;
        end
    end
`endif

endmodule

// File: rtl/keys_in.sv
// rtl/keys_in.sv - debounced key inputs with press/release event FIFO (optional auto-repeat: KEYS_IN_AUTOREPEAT_EN)
module keys_in
    import keys_in_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_CYCLES   = 25000000,
    localparam int KW             = key_idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] keys_raw,
    output logic [WIDTH-1:0] keys_level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [KW-1:0]    evt_key,
    output logic             evt_press,
    output logic             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] pulse;
    logic [WIDTH-1:0] pulse_dir;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pend_dir;
    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] req_dir;
    logic [WIDTH-1:0] grant;
    logic [KW-1:0]    sel;
    logic             any_req;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    evt_t             push_evt;
    evt_t             mem [FIFO_DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        keys_in_chan #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEYS_IN_AUTOREPEAT_EN
            ,
            .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
        ) u_chan (
            .clk        (clk),
            .rstn       (rstn),
            .raw        (keys_raw[g]),
            .level      (keys_level[g]),
            .edge_pulse (pulse[g]),
            .edge_dir   (pulse_dir[g])
        );
    end

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop   = !empty && evt_ready;

    // A fresh edge on an idle channel bypasses the pending flop so an
    // event reaches the FIFO the cycle after the level changes.
    always_comb begin
        req     = pending | pulse;
        req_dir = (pending & pend_dir) | (~pending & pulse_dir);
        any_req = 1'b0;
        sel     = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_req = 1'b1;
                sel     = KW'(i);
            end
        end
        push           = any_req && (!full || pop);
        grant          = push ? (WIDTH'(1) << sel) : '0;
        push_evt.key   = KEY_MAX_W'(sel);
        push_evt.press = req_dir[sel];
    end

    // Pending stage: holds one event per channel while the FIFO is busy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending  <= '0;
            pend_dir <= '0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (grant[i]) begin
                    pending[i]  <= pending[i] & pulse[i];
                    pend_dir[i] <= pulse_dir[i];
                end else if (pulse[i] && !pending[i]) begin
                    pending[i]  <= 1'b1;
                    pend_dir[i] <= pulse_dir[i];
                end
            end
            if (|(pulse & pending & ~grant)) begin
                overflow <= 1'b1;
            end
        end
    end

    // Event FIFO storage and pointers; a push into a full FIFO needs a pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= push_evt;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign evt_valid = !empty;
    assign evt_key   = empty ? '0 : mem[rptr].key[KW-1:0];
    assign evt_press = !empty && mem[rptr].press;

endmodule

// File: tb/tb_keys_in.sv
// tb/tb_keys_in.sv - directed self-checking bench for keys_in
module tb_keys_in;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] keys_raw;
    logic [1:0] keys_level;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_key;
    logic       evt_press;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    keys_in #(
        .WIDTH           (2),
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (4),
        .FIFO_DEPTH      (4),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .keys_raw   (keys_raw),
        .keys_level (keys_level),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_key    (evt_key),
        .evt_press  (evt_press),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rstn      = 1'b0;
        keys_raw  = 2'b11;
        evt_ready = 1'b0;
        step(3);
        chk("reset_level", keys_level, 2'b00);
        chk("reset_valid", evt_valid, 1'b0);
        chk("reset_key", evt_key, 1'b0);
        chk("reset_press", evt_press, 1'b0);
        chk("reset_ovf", overflow, 1'b0);
        rstn = 1'b1;
        step(3);
        chk("idle_valid", evt_valid, 1'b0);

        // Single press on key0: level after exactly 6 edges, event one later.
        keys_raw = 2'b10;
        step(5);
        chk("t1_level_early", keys_level, 2'b00);
        step(1);
        chk("t1_level", keys_level, 2'b01);
        chk("t1_valid_same", evt_valid, 1'b0);
        step(1);
        chk("t1_valid", evt_valid, 1'b1);
        chk("t1_key", evt_key, 1'b0);
        chk("t1_press", evt_press, 1'b1);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        chk("t1_popped", evt_valid, 1'b0);

        // Three-cycle glitch on key1 is rejected.
        keys_raw = 2'b00;
        step(3);
        keys_raw = 2'b10;
        step(10);
        chk("t2_level", keys_level, 2'b01);
        chk("t2_valid", evt_valid, 1'b0);
        chk("t2_ovf", overflow, 1'b0);

        // Release key0 and check the release event.
        keys_raw = 2'b11;
        step(8);
        chk("rel_level", keys_level, 2'b00);
        chk("rel_valid", evt_valid, 1'b1);
        chk("rel_key", evt_key, 1'b0);
        chk("rel_press", evt_press, 1'b0);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        chk("rel_popped", evt_valid, 1'b0);

        // Both keys together: key0 then key1 on consecutive cycles.
        evt_ready = 1'b1;
        keys_raw  = 2'b00;
        step(6);
        chk("t3_level", keys_level, 2'b11);
        chk("t3_valid0", evt_valid, 1'b0);
        step(1);
        chk("t3_valid_a", evt_valid, 1'b1);
        chk("t3_key_a", evt_key, 1'b0);
        chk("t3_press_a", evt_press, 1'b1);
        step(1);
        chk("t3_valid_b", evt_valid, 1'b1);
        chk("t3_key_b", evt_key, 1'b1);
        chk("t3_press_b", evt_press, 1'b1);
        step(1);
        chk("t3_drained", evt_valid, 1'b0);
        evt_ready = 1'b0;

        // Fill the FIFO with key0 toggles, fifth pends, sixth overflows.
        for (int i = 0; i < 5; i++) begin
            keys_raw[0] = ~keys_raw[0];
            step(8);
        end
        chk("t4_valid", evt_valid, 1'b1);
        chk("t4_ovf_clear", overflow, 1'b0);
        chk("t4_level", keys_level, 2'b10);
        keys_raw[0] = ~keys_raw[0];
        step(8);
        chk("t4_ovf_set", overflow, 1'b1);
        chk("t4_level6", keys_level, 2'b11);
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_drain%0d_valid", i), evt_valid, 1'b1);
            chk($sformatf("t4_drain%0d_key", i), evt_key, 1'b0);
            chk($sformatf("t4_drain%0d_press", i), evt_press, (i % 2 == 0) ? 1'b0 : 1'b1);
            step(1);
        end
        chk("t4_drained", evt_valid, 1'b0);
        chk("t4_ovf_sticky", overflow, 1'b1);
        evt_ready = 1'b0;

        // Reset while three events are queued.
        for (int i = 0; i < 3; i++) begin
            keys_raw[0] = ~keys_raw[0];
            step(8);
        end
        chk("t5_valid", evt_valid, 1'b1);
        chk("t5_level", keys_level, 2'b10);
        rstn = 1'b0;
        #2;
        chk("t5_rst_valid", evt_valid, 1'b0);
        chk("t5_rst_level", keys_level, 2'b00);
        chk("t5_rst_ovf", overflow, 1'b0);
        keys_raw = 2'b11;
        step(2);
        rstn = 1'b1;
        step(12);
        chk("t5_idle_valid", evt_valid, 1'b0);
        chk("t5_idle_level", keys_level, 2'b00);
        chk("t5_idle_ovf", overflow, 1'b0);

`ifdef KEYS_IN_AUTOREPEAT_EN
        // Hold key0 long enough for three repeats, then let go.
        begin
            int n_press;
            int n_rel;
            n_press   = 0;
            n_rel     = 0;
            evt_ready = 1'b1;
            keys_raw  = 2'b10;
            for (int i = 0; i < 31; i++) begin
                step(1);
                if (evt_valid) begin
                    if (evt_press) n_press++;
                    else n_rel++;
                end
            end
            keys_raw = 2'b11;
            for (int i = 0; i < 14; i++) begin
                step(1);
                if (evt_valid) begin
                    if (evt_press) n_press++;
                    else n_rel++;
                end
            end
            chk("ar_presses", n_press, 4);
            chk("ar_releases", n_rel, 1);
            chk("ar_ovf", overflow, 1'b0);
            evt_ready = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keys_in.md
Name: keys_in

Overview:
- Input-side counterpart to the LED output path: samples raw board pushbuttons/switches, synchronises and debounces them, and reports stable levels.
- Press/release edges are queued as events in a small FIFO, drained with a valid/ready handshake.
- Sits between board pins and user logic on the de0nano top level.
- Runs on sys_clk, not on a clkdiv output.

Parameters:
- WIDTH, 2, number of key inputs (DE0-Nano KEY[1:0]); 1..16
- ACTIVE_LOW, 1, 1 = raw pin low means pressed
- DEBOUNCE_CYCLES, 50000, cycles a new level must persist before it is accepted (1 ms at 50 MHz); >= 2
- FIFO_DEPTH, 4, event FIFO entries; power of two, >= 2
- REPEAT_CYCLES, 25000000, auto-repeat period; used only with the optional feature

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- keys_raw  in  WIDTH  raw asynchronous pin levels
- keys_level  out  WIDTH  debounced level, 1 = pressed (polarity normalised)
- evt_valid  out  1  event FIFO non-empty
- evt_ready  in  1  consumer accepts the head event
- evt_key  out  max(1,clog2(WIDTH))  index of key for the head event
- evt_press  out  1  1 = press event, 0 = release event
- overflow  out  1  sticky flag: an event was lost

Behaviour:
- Reset (async, rstn low):
  - synchroniser flops load the inactive pin level (1 if ACTIVE_LOW).
  - keys_level = 0, debounce counters = 0, pending flags = 0.
  - FIFO empty, evt_valid = 0, evt_key = 0, evt_press = 0, overflow = 0.
  - Reset mid-operation discards all queued and pending events.
- Per channel:
  - 2-flop synchroniser, then polarity normalisation.
  - Debounce counter: while the normalised sample differs from keys_level, increment.
    - If the sample matches keys_level again, clear the counter to 0.
    - When the counter reaches DEBOUNCE_CYCLES-1 and the sample still differs: toggle keys_level, clear the counter, emit a one-cycle edge pulse (dir = new level).
  - Latency, raw change to keys_level: 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no level change and no event.
- Pending stage:
  - An edge pulse sets the channel's pending flag and dir.
  - Edge while pending is still set: the new event is dropped, the pending entry is kept, overflow <= 1.
  - overflow is sticky until reset.
- Arbiter:
  - Each cycle, if the FIFO can accept, the lowest-index pending channel is pushed as {key, dir} and its pending flag is cleared.
  - One push per cycle; an edge arriving in the same cycle its own pending entry is pushed re-sets pending (no overflow).
- FIFO:
  - Registered; evt_valid = !empty; evt_key/evt_press show the head entry, stable while evt_valid && !evt_ready.
  - Pop on evt_valid && evt_ready.
  - Push accepted when !full, or when full with a pop in the same cycle.
  - Push into an empty FIFO: evt_valid rises the next cycle.
  - Full with no pop: pending flags hold, nothing is lost until a second edge arrives on the same channel.
  - Pointers wrap modulo FIFO_DEPTH; occupancy count is clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: KEYS_IN_AUTOREPEAT_EN.
- When defined:
  - Each channel has a repeat counter that runs while keys_level = 1 and clears when keys_level = 0 or on any edge.
  - On reaching REPEAT_CYCLES-1 it issues an extra press event (dir = 1) through the pending stage, then restarts.
  - Same overflow rules apply.
- When undefined: no repeat logic; only real edges produce events, and REPEAT_CYCLES is ignored.

Decomposition:
- Package keys_in_pkg:
  - event struct typedef {key index, press bit}
  - KEY_IDX_W helper function
  - EVT_RELEASE/EVT_PRESS constants
- One natural sub-module, keys_in_chan:
  - contains the synchroniser, debounce counter, optional repeat counter and edge pulse.
  - instantiated WIDTH times via generate.
- Arbiter and FIFO stay in the top.

Test Plan (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, WIDTH=2, ACTIVE_LOW=1):
- Reset, then keys_raw[0] 1->0 held 10 cycles -> keys_level[0]=1 exactly 6 cycles after the change; one event {key0, press}; evt_valid the next cycle.
- keys_raw[1] low for 3 cycles then high -> no level change, evt_valid stays 0, overflow stays 0.
- Both keys pressed in the same cycle, evt_ready=1 -> two events in consecutive cycles, key0 first then key1, both press.
- evt_ready=0; key0 toggled 5 times (each held 6 cycles):
  - FIFO holds 4 events, 5th stays pending, overflow=0.
  - 6th toggle -> overflow=1; after draining, 5 events seen in order.
- rstn pulsed low while the FIFO holds 3 events -> evt_valid=0 and keys_level=0 asynchronously; no events after release with keys idle.
- With KEYS_IN_AUTOREPEAT_EN, REPEAT_CYCLES=8: key0 held 30 cycles after debounce -> 1 press + 3 repeat presses, then a release on let-go.
